ts_src_sched: RTL
=================

# ts_src_sched

Per-packet source scheduler in front of the DVB-T modulator's TS input. It sequences three sources of 188-byte TS packets: a live FIFO, the PRBS test-pattern generator, and an internal null-packet generator. It emits one continuous byte stream, paced by the downstream byte strobe, and switches source only on packet boundaries. It parks the pattern generator on a sync byte so pattern packets can be spliced without misalignment.

## Interface
- PKT_LEN, 188, bytes per TS packet (fixed).
- CNT_W, 16, width of stuffing counter.
- iclk  in  1  clock.
- irst  in  1  reset, synchronous, active-high.
- irdy  in  1  downstream byte request; one byte per high cycle.
- imode  in  2  0: live, null stuffing; 1: pattern only; 2: null only; 3: live, pattern stuffing.
- ilive_avail  in  1  live FIFO holds ≥188 bytes.
- olive_rd  out  1  live FIFO read strobe; data valid next cycle on ilive_dat.
- ilive_dat  in  8  live FIFO data.
- opat_rdy  out  1  pattern generator advance strobe.
- ipat_dat  in  8  pattern byte; updates the cycle after each opat_rdy.
- ipat_sop  in  1  high while ipat_dat holds a sync byte.
- odat  out  8  output byte.
- osop  out  1  high on byte 0 of each packet.
- oval  out  1  odat valid.
- osrc  out  2  source of current packet (0 live, 1 pattern, 2 null).
- osync_err  out  1  pulse: live packet byte 0 ≠ 0x47.
- opat_err  out  1  pulse: pattern generator misaligned at packet end.
- ostuff_cnt  out  CNT_W  stuffed (null or pattern-in-mode-3) packets, wraps.

## Operation
- Byte counter bcnt 0..187 advances on each irdy cycle and wraps 187→0.
- Source decision is made at bcnt==0 with irdy high, from the current imode/ilive_avail. It is held for 188 irdy cycles. imode changes mid-packet take effect at the next boundary.
- Decision rules:
  - mode 0: live if ilive_avail, else null.
  - mode 1: pattern if PARKED, else null.
  - mode 2: null.
  - mode 3: live if ilive_avail, else pattern if PARKED, else null.
- ostuff_cnt increments on every decision other than live in modes 0/3.
- Live: olive_rd = irdy & live granted (combinational). Exactly 188 reads per packet. If byte 0 read ≠ 0x47, osync_err pulses with that byte's oval; the packet still passes through.
- Null: bytes 0x47, 0x1F, 0xFF, 0x10, then 184 × 0xFF, selected by bcnt.
- Pattern FSM:
  - PRIME: opat_rdy=1 every cycle, irdy ignored, until ipat_sop=1 → PARKED.
  - PARKED: opat_rdy=0; sync byte held on ipat_dat.
  - On grant → ACTIVE.
  - ACTIVE: opat_rdy = irdy. ipat_dat is captured on each strobe, giving 188 strobes per packet.
  - End of packet with ipat_sop=1 → PARKED.
  - End of packet with ipat_sop=0 → PRIME and pulse opat_err.
- irst mid-packet: the partial packet is abandoned and the FSM returns to PRIME. The upstream FIFO must share irst.

## Timing
- Reset values: odat=0, osop=0, oval=0, osrc=2, osync_err=0, opat_err=0, ostuff_cnt=0, bcnt=0, FSM=PRIME. olive_rd and opat_rdy are forced 0 while irst is high.
- Fixed latency: irdy at cycle t → oval/odat/osop at t+2, for all sources.
  - Stage 1 (t): records source and bcnt; pattern byte captured into a register.
  - Stage 2 (t+1): mux of ilive_dat / pattern register / null byte.
  - Output register at t+2.
- oval is irdy delayed by 2 cycles. No bubbles on source switches; back-to-back packets from different sources are contiguous.
- The boundary decision and the first olive_rd occur in the same cycle.
- Simultaneous end-of-pattern-packet with ipat_sop=0 and the next boundary decision: the pattern source is unavailable for that decision, so null (mode 1) or live/null (mode 3) is chosen.

## Structure
- Package ts_sched_pkg holds:
  - PKT_LEN=188, SYNC_BYTE=8'h47, NULL_PID=13'h1FFF.
  - Source enum {SRC_LIVE, SRC_PAT, SRC_NULL}.
  - Pattern FSM state enum {PRIME, PARKED, ACTIVE}.
  - Null-byte function of bcnt.
- One sub-module: ts_null_src (bcnt → null-packet byte, registered to match the stage-2 timing).

## Test plan
- Mode 2 with irdy held high, 376 cycles: two packets; each reads 47 1F FF 10 FF…; osop every 188 oval cycles; ostuff_cnt=2.
- Mode 0 with ilive_avail=1, FIFO loaded with 2 packets: 376 olive_rd pulses; output equals FIFO contents shifted by 2 cycles; osrc=0; ostuff_cnt=0.
- Mode 3 with ilive_avail dropped after packet 1: packet 2 comes from pattern; its osop lands on 0x47; ostuff_cnt=1; opat_err stays 0.
- Mode 1 with irdy toggling 50%: correct pattern bytes, no gaps in content, oval mirrors irdy delayed by 2.
- Live packet whose byte 0 is 0x00 → osync_err pulses exactly once, aligned with that osop.
- irst at bcnt=90 of a pattern packet: all outputs return to reset values next cycle, FSM re-primes, and the next output packet starts with 0x47.

Source files
------------

// File: rtl/ts_sched_pkg.sv
// Shared types and constants for the TS source scheduler: packet geometry,
// source / pattern-FSM encodings and the null-packet byte table.
package ts_sched_pkg;

  localparam int          PKT_LEN   = 188;
  localparam logic [7:0]  SYNC_BYTE = 8'h47;
  localparam logic [12:0] NULL_PID  = 13'h1FFF;

  typedef enum logic [1:0] {
    SRC_LIVE = 2'd0,
    SRC_PAT  = 2'd1,
    SRC_NULL = 2'd2
  } src_t;

  typedef enum logic [1:0] {
    PRIME  = 2'd0,
    PARKED = 2'd1,
    ACTIVE = 2'd2
  } pat_st_t;

  // Null packet: sync, PID 0x1FFF, payload-only/CC=0, then 0xFF stuffing.
  function automatic logic [7:0] null_byte(input logic [7:0] bcnt);
    logic [7:0] b;
    case (bcnt)
      8'd0:    b = SYNC_BYTE;
      8'd1:    b = {3'b000, NULL_PID[12:8]};
      8'd2:    b = NULL_PID[7:0];
      8'd3:    b = 8'h10;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ts_null_src.sv
// Null-packet byte source: byte position in, registered null byte out one
// cycle later so it lines up with the live FIFO data and the pattern register.
module ts_null_src
  import ts_sched_pkg::*;
(
  input  logic       iclk,
  input  logic       irst,
  input  logic [7:0] ibcnt,
  output logic [7:0] odat
);

  always_ff @(posedge iclk) begin
    if (irst) odat <= 8'h00;
    else      odat <= null_byte(ibcnt);
  end

endmodule

// File: rtl/ts_src_sched.sv
// Per-packet source scheduler: live FIFO / PRBS pattern / null packets,
// switched only on packet boundaries, fixed two-cycle irdy-to-oval latency.
//
// state  | meaning
// PRIME  | strobing the pattern generator until it shows a sync byte
// PARKED | generator holds a sync byte, ready to be spliced in
// ACTIVE | pattern packet in progress, generator advances on irdy
module ts_src_sched
  import ts_sched_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             irdy,
  input  logic [1:0]       imode,
  input  logic             ilive_avail,
  output logic             olive_rd,
  input  logic [7:0]       ilive_dat,
  output logic             opat_rdy,
  input  logic [7:0]       ipat_dat,
  input  logic             ipat_sop,
  output logic [7:0]       odat,
  output logic             osop,
  output logic             oval,
  output logic [1:0]       osrc,
  output logic             osync_err,
  output logic             opat_err,
  output logic [CNT_W-1:0] ostuff_cnt
);

  localparam logic [7:0] LAST = 8'(PKT_LEN - 1);

  logic [7:0] bcnt;
  src_t       src_q, dec, cur_src, s1_src;
  pat_st_t    st_q, st_d;
  logic       pat_end_q, pat_avail, boundary, grant_pat;
  logic       pat_rdy, pat_err_d;
  logic       s1_val, s1_sop;
  logic [7:0] pat_q, null_q, mux_dat;

  assign boundary  = irdy && (bcnt == 8'd0);
  // The cycle after the last pattern strobe the generator may already sit on
  // the next sync byte; treat that as parked so pattern packets run back-to-back.
  assign pat_avail = (st_q == PARKED) || ((st_q == ACTIVE) && pat_end_q && ipat_sop);

  always_comb begin
    dec = SRC_NULL;
    case (imode)
      2'd0:    dec = ilive_avail ? SRC_LIVE : SRC_NULL;
      2'd1:    dec = pat_avail ? SRC_PAT : SRC_NULL;
      2'd2:    dec = SRC_NULL;
      default: dec = ilive_avail ? SRC_LIVE : (pat_avail ? SRC_PAT : SRC_NULL);
    endcase
  end

  assign cur_src   = boundary ? dec : src_q;
  assign grant_pat = boundary && (dec == SRC_PAT);
  assign olive_rd  = !irst && irdy && (cur_src == SRC_LIVE);
  assign opat_rdy  = !irst && pat_rdy;

  always_comb begin
    st_d      = st_q;
    pat_rdy   = 1'b0;
    pat_err_d = 1'b0;
    case (st_q)
      PRIME: begin
        pat_rdy = !ipat_sop;
        if (ipat_sop) st_d = PARKED;
      end
      PARKED: begin
        if (grant_pat) begin
          st_d    = ACTIVE;
          pat_rdy = 1'b1;
        end
      end
      ACTIVE: begin
        if (!pat_end_q) begin
          pat_rdy = irdy;
        end else if (grant_pat) begin
          pat_rdy = 1'b1;
        end else if (ipat_sop) begin
          st_d = PARKED;
        end else begin
          st_d      = PRIME;
          pat_err_d = 1'b1;
        end
      end
      default: st_d = PRIME;
    endcase
  end

  ts_null_src u_null (
    .iclk  (iclk),
    .irst  (irst),
    .ibcnt (bcnt),
    .odat  (null_q)
  );

  always_comb begin
    case (s1_src)
      SRC_LIVE: mux_dat = ilive_dat;
      SRC_PAT:  mux_dat = pat_q;
      default:  mux_dat = null_q;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      bcnt       <= 8'd0;
      src_q      <= SRC_NULL;
      st_q       <= PRIME;
      pat_end_q  <= 1'b0;
      pat_q      <= 8'h00;
      s1_val     <= 1'b0;
      s1_sop     <= 1'b0;
      s1_src     <= SRC_NULL;
      odat       <= 8'h00;
      osop       <= 1'b0;
      oval       <= 1'b0;
      osrc       <= SRC_NULL;
      osync_err  <= 1'b0;
      opat_err   <= 1'b0;
      ostuff_cnt <= '0;
    end else begin
      st_q      <= st_d;
      pat_end_q <= (st_q == ACTIVE) && irdy && (bcnt == LAST);
      opat_err  <= pat_err_d;
      if (irdy) bcnt <= (bcnt == LAST) ? 8'd0 : bcnt + 8'd1;
      if (boundary) begin
        src_q <= dec;
        if (dec != SRC_LIVE) ostuff_cnt <= ostuff_cnt + CNT_W'(1);
      end
      if (opat_rdy) pat_q <= ipat_dat;

      s1_val <= irdy;
      s1_sop <= boundary;
      s1_src <= cur_src;

      oval      <= s1_val;
      osop      <= s1_val && s1_sop;
      osync_err <= s1_val && s1_sop && (s1_src == SRC_LIVE) && (ilive_dat != SYNC_BYTE);
      if (s1_val) begin
        odat <= mux_dat;
        osrc <= s1_src;
      end
    end
  end

endmodule
